// File: rtl/speed_ramp.sv
// Speed ramp controller: slews a registered speed code toward a commanded target,
// one STEP every STEP_DIV cycles, with a level-sensitive emergency stop.
module speed_ramp #(
  parameter int unsigned STEP_DIV  = 1000,
  parameter int unsigned STEP      = 1,
  parameter int unsigned MAX_SPEED = 199
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid_i,
  input  logic [7:0] cmd_speed_i,
  output logic       cmd_ready_o,
  input  logic       estop_i,
  output logic [7:0] speed_out_o,
  output logic       busy_o,
  output logic       at_target_o
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RAMP_UP   = 2'd1,
    S_RAMP_DOWN = 2'd2,
    S_STOP      = 2'd3
  } state_e;

  localparam logic [9:0] CNT_LAST = 10'(STEP_DIV - 1);
  localparam logic [8:0] STEP9    = 9'(STEP);
  localparam logic [7:0] MAX8     = 8'(MAX_SPEED);

  state_e     state_q, state_d;
  logic [7:0] speed_q, speed_d;
  logic [7:0] target_q, target_d;
  logic [9:0] cnt_q, cnt_d;

  logic       ramping;
  logic       tick;
  logic       cmd_ready;
  logic       accept;
  logic [7:0] cmd_target;
  logic [9:0] cnt_next;
  logic [8:0] sum9;
  logic [8:0] diff9;
  logic [7:0] up_speed;
  logic [7:0] dn_speed;

  assign ramping    = (state_q == S_RAMP_UP) || (state_q == S_RAMP_DOWN);
  assign tick       = ramping && (cnt_q == CNT_LAST);
  assign cmd_ready  = !estop_i && (state_q != S_STOP);
  assign accept     = cmd_valid_i && cmd_ready;
  assign cmd_target = (cmd_speed_i > MAX8) ? MAX8 : cmd_speed_i;
  assign cnt_next   = tick ? 10'd0 : cnt_q + 10'd1;

  // Nine-bit step arithmetic: the carry/borrow bit catches overshoot past MAX or below 0.
  assign sum9     = {1'b0, speed_q} + STEP9;
  assign diff9    = {1'b0, speed_q} - STEP9;
  assign up_speed = (sum9 >= {1'b0, target_q}) ? target_q : sum9[7:0];
  assign dn_speed = (diff9[8] || (diff9 <= {1'b0, target_q})) ? target_q : diff9[7:0];

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; the whole register set, including target, is reset asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      speed_q  <= 8'd0;
      target_q <= 8'd0;
      cnt_q    <= 10'd0;
    end else begin
      speed_q  <= speed_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (estop_i) begin
      state_d = S_STOP;
    end else if (state_q == S_STOP) begin
      state_d = S_IDLE;
    end else if (accept) begin
      if (cmd_target > speed_q) begin
        state_d = S_RAMP_UP;
      end else if (cmd_target < speed_q) begin
        state_d = S_RAMP_DOWN;
      end else begin
        state_d = S_IDLE;
      end
    end else if (ramping && (speed_q == target_q)) begin
      state_d = S_IDLE;
    end
  end

  // Datapath next state; an accepted command wins over a coincident tick.
  always_comb begin
    speed_d  = speed_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    if (estop_i) begin
      speed_d  = 8'd0;
      target_d = 8'd0;
      cnt_d    = 10'd0;
    end else if (state_q == S_STOP) begin
      cnt_d = 10'd0;
    end else if (accept) begin
      target_d = cmd_target;
      if ((state_q == S_IDLE) || (state_d == S_IDLE)) begin
        cnt_d = 10'd0;
      end else begin
        cnt_d = cnt_next;
      end
    end else if (ramping) begin
      if (speed_q == target_q) begin
        cnt_d = 10'd0;
      end else begin
        cnt_d = cnt_next;
        if (tick) begin
          speed_d = (state_q == S_RAMP_UP) ? up_speed : dn_speed;
        end
      end
    end
  end

  always_comb begin
    cmd_ready_o = cmd_ready;
    busy_o      = ramping;
    at_target_o = (state_q == S_IDLE) && (speed_q == target_q);
    speed_out_o = speed_q;
  end

endmodule

// File: tb/tb_speed_ramp.sv
// Directed bench for speed_ramp: unit-step instance (dut_a) and STEP=3 instance (dut_b),
// both with STEP_DIV=4, expected values hand-computed from the ramp timing.
module tb_speed_ramp;

  logic       clk;
  logic       rst_n;
  logic       a_valid, a_estop, a_ready, a_busy, a_at;
  logic [7:0] a_cmd, a_out;
  logic       b_valid, b_estop, b_ready, b_busy, b_at;
  logic [7:0] b_cmd, b_out;

  int n_checks = 0;
  int n_errors = 0;

  speed_ramp #(.STEP_DIV(4), .STEP(1), .MAX_SPEED(199)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(a_valid), .cmd_speed_i(a_cmd), .cmd_ready_o(a_ready),
    .estop_i(a_estop), .speed_out_o(a_out), .busy_o(a_busy), .at_target_o(a_at)
  );

  speed_ramp #(.STEP_DIV(4), .STEP(3), .MAX_SPEED(199)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(b_valid), .cmd_speed_i(b_cmd), .cmd_ready_o(b_ready),
    .estop_i(b_estop), .speed_out_o(b_out), .busy_o(b_busy), .at_target_o(b_at)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic stepn(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int max_seen;
    rst_n   = 1'b1;
    a_valid = 1'b0; a_estop = 1'b0; a_cmd = 8'd0;
    b_valid = 1'b0; b_estop = 1'b0; b_cmd = 8'd0;
    #2 rst_n = 1'b0;
    #10;
    check("rst_speed",  a_out,   0);
    check("rst_busy",   a_busy,  0);
    check("rst_at",     a_at,    1);
    check("rst_ready",  a_ready, 1);
    check("rst_b_speed", b_out,  0);
    @(negedge clk) rst_n = 1'b1;
    step();

    // Ramp 0 -> 5: one unit every 4 cycles, 5 reached 20 edges after acceptance.
    a_cmd = 8'd5; a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    check("up5_busy0", a_busy, 1);
    check("up5_spd0",  a_out,  0);
    check("up5_at0",   a_at,   0);
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 3)  check("up5_e3",  a_out, 0);
      if (k == 4)  check("up5_e4",  a_out, 1);
      if (k == 8)  check("up5_e8",  a_out, 2);
      if (k == 19) check("up5_e19", a_out, 4);
      if (k == 20) check("up5_e20", a_out, 5);
    end
    check("up5_busy20", a_busy, 1);
    step();
    check("up5_idle_busy", a_busy, 0);
    check("up5_idle_at",   a_at,   1);

    // Emergency stop at speed 7 with a command held valid.
    a_cmd = 8'd10; a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    stepn(8);
    check("es_pre_spd", a_out, 7);
    a_estop = 1'b1; a_cmd = 8'd9; a_valid = 1'b1;
    #1 check("es_ready_comb", a_ready, 0);
    step();
    check("es_spd",   a_out,   0);
    check("es_busy",  a_busy,  0);
    check("es_ready", a_ready, 0);
    stepn(3);
    check("es_hold_spd",  a_out,  0);
    check("es_hold_busy", a_busy, 0);
    a_estop = 1'b0;
    #1 check("es_stop_ready", a_ready, 0);
    step();
    check("es_exit_busy",  a_busy,  0);
    check("es_exit_spd",   a_out,   0);
    check("es_exit_at",    a_at,    1);
    check("es_exit_ready", a_ready, 1);
    a_valid = 1'b0;

    // Command on a tick edge: target 8, speed 2, cmd 4 -> step dropped.
    a_cmd = 8'd8; a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    stepn(11);
    check("tk_pre_spd", a_out, 2);
    a_cmd = 8'd4; a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    check("tk_drop_spd",  a_out,  2);
    check("tk_drop_busy", a_busy, 1);
    stepn(3);
    check("tk_e15", a_out, 2);
    step();
    check("tk_e16", a_out, 3);
    stepn(4);
    check("tk_e20", a_out, 4);
    step();
    check("tk_idle_busy", a_busy, 0);
    check("tk_idle_at",   a_at,   1);

    // Retarget mid-ramp: toward 10, at speed 6 accept 3 -> 5,4,3 without counter restart.
    a_cmd = 8'd10; a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    stepn(8);
    check("rt_e8", a_out, 6);
    step();
    a_cmd = 8'd3; a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    check("rt_e10_spd",  a_out,  6);
    check("rt_e10_busy", a_busy, 1);
    step();
    check("rt_e11", a_out, 6);
    step();
    check("rt_e12", a_out, 5);
    stepn(4);
    check("rt_e16", a_out, 4);
    stepn(4);
    check("rt_e20", a_out, 3);
    check("rt_e20_busy", a_busy, 1);
    step();
    check("rt_idle_busy", a_busy, 0);
    check("rt_idle_at",   a_at,   1);

    // Out-of-range command clamps to 199; track the peak over the whole ramp.
    a_cmd = 8'd250; a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    max_seen = 0;
    for (int k = 0; k < 800; k++) begin
      step();
      if (int'(a_out) > max_seen) max_seen = int'(a_out);
    end
    check("clamp_peak", max_seen, 199);
    check("clamp_spd",  a_out,    199);
    check("clamp_at",   a_at,     1);
    check("clamp_busy", a_busy,   0);

    // STEP=3: 0 -> 7 via 3,6,7 then back to 0 via 4,1,0.
    b_cmd = 8'd7; b_valid = 1'b1;
    step();
    b_valid = 1'b0;
    stepn(4);
    check("s3_up1", b_out, 3);
    stepn(4);
    check("s3_up2", b_out, 6);
    stepn(4);
    check("s3_up3", b_out, 7);
    step();
    check("s3_up_at", b_at, 1);
    b_cmd = 8'd0; b_valid = 1'b1;
    step();
    b_valid = 1'b0;
    stepn(4);
    check("s3_dn1", b_out, 4);
    stepn(4);
    check("s3_dn2", b_out, 1);
    stepn(4);
    check("s3_dn3", b_out, 0);
    step();
    check("s3_dn_at",   b_at,   1);
    check("s3_dn_busy", b_busy, 0);

    // Reset asserted between edges mid-ramp clears speed immediately.
    b_cmd = 8'd7; b_valid = 1'b1;
    step();
    b_valid = 1'b0;
    stepn(5);
    check("s3_mid_spd",  b_out,  3);
    check("s3_mid_busy", b_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_b_spd",  b_out,  0);
    check("arst_b_busy", b_busy, 0);
    check("arst_b_at",   b_at,   1);
    check("arst_a_spd",  a_out,  0);
    @(negedge clk) rst_n = 1'b1;
    step();
    check("post_rst_spd",  b_out,  0);
    check("post_rst_busy", b_busy, 0);
    stepn(4);
    check("post_rst_hold", b_out, 0);
    check("post_rst_at",   b_at,  1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
